// File: rtl/arbiter_grant_mux.sv
// Requester-side datapath beside a round-robin arbiter: per-requester FIFOs drive `request`,
// and the granted head word is forwarded on a valid/ready port. ARBITER_GRANT_MUX_EARLY_ACK_EN
// releases the grant combinationally in the capture cycle instead of after the downstream accept.
module arbiter_grant_mux #(
    parameter int unsigned P_REQUESTER_NUM = 3,
    parameter int unsigned P_DATA_W        = 32,
    parameter int unsigned P_FIFO_DEPTH    = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [P_REQUESTER_NUM*P_DATA_W-1:0] in_data,
    input  logic [P_REQUESTER_NUM-1:0]          in_valid,
    output logic [P_REQUESTER_NUM-1:0]          in_ready,
    output logic [P_REQUESTER_NUM-1:0]          request,
    input  logic [P_REQUESTER_NUM-1:0]          grant_valid,
    output logic                                grant_ready,
    output logic [P_DATA_W-1:0]                 out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                grant_err
);
    localparam int unsigned PtrW = $clog2(P_FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned IdxW = (P_REQUESTER_NUM > 1) ? $clog2(P_REQUESTER_NUM) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StAck} state_e;

    logic [P_DATA_W-1:0] mem_q [P_REQUESTER_NUM][P_FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q [P_REQUESTER_NUM];
    logic [PtrW-1:0]     rd_ptr_q [P_REQUESTER_NUM];
    logic [CntW-1:0]     cnt_q [P_REQUESTER_NUM];

    logic [P_REQUESTER_NUM-1:0] push, pop, full, empty;

    state_e                     state_q, state_d;
    logic [P_REQUESTER_NUM-1:0] gnt_q, gnt_d;
    logic [P_DATA_W-1:0]        data_q, data_d;
    logic                       err_q, err_d;

    logic [IdxW-1:0]     grant_idx;
    logic                grant_onehot, grant_ok;
    logic [P_DATA_W-1:0] head;

    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
            full[i]  = (cnt_q[i] == CntW'(P_FIFO_DEPTH));
            empty[i] = (cnt_q[i] == '0);
            // full is taken from the registered count, so a same-cycle pop never frees a slot
            push[i]  = in_valid[i] & ~full[i];
        end
    end

    assign in_ready = ~full;
    assign request  = ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                cnt_q[i] <= cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*P_DATA_W +: P_DATA_W];
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
            if (grant_valid[i]) grant_idx = IdxW'(i);
        end
    end

    assign grant_onehot = (grant_valid != '0) && ((grant_valid & (grant_valid - 1'b1)) == '0);
    assign grant_ok     = grant_onehot && ((grant_valid & request) != '0);
    assign head         = mem_q[grant_idx][rd_ptr_q[grant_idx]];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        err_d   = err_q;
        pop     = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_ok) begin
                    gnt_d          = grant_valid;
                    data_d         = head;
                    pop[grant_idx] = 1'b1;
                    state_d        = StSend;
                end else if (grant_valid != '0) begin
                    err_d = 1'b1;
                end
            end
            StSend: begin
`ifdef ARBITER_GRANT_MUX_EARLY_ACK_EN
                if (out_ready) state_d = StIdle;
`else
                if (grant_valid != gnt_q) err_d = 1'b1;
                if (out_ready) state_d = StAck;
`endif
            end
            StAck: begin
                if (grant_valid != gnt_q) err_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == StSend);
    assign out_data  = data_q;
    assign grant_err = err_q;

`ifdef ARBITER_GRANT_MUX_EARLY_ACK_EN
    assign grant_ready = (state_q == StIdle) && grant_ok;
`else
    assign grant_ready = (state_q == StAck);
`endif

endmodule

// File: doc/arbiter_grant_mux.md
# arbiter_grant_mux

Requester-side datapath partner of the weighted round-robin arbiter. It buffers payloads from P_REQUESTER_NUM sources in per-requester FIFOs and drives the arbiter's `request` vector from FIFO occupancy. It consumes the arbiter's one-hot `grant_valid`, forwards the granted requester's head word to a single valid/ready output, and returns `grant_ready` to release the grant. It sits between the source channels and the shared downstream resource, with the arbiter beside it.

## Interface
- P_REQUESTER_NUM, 3, number of requesters; must match the paired arbiter.
- P_DATA_W, 32, payload width.
- P_FIFO_DEPTH, 4, entries per requester FIFO; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  P_REQUESTER_NUM*P_DATA_W  payload per requester; requester i occupies bits [i*P_DATA_W +: P_DATA_W].
- in_valid  in  P_REQUESTER_NUM  per-requester push strobe.
- in_ready  out  P_REQUESTER_NUM  per-requester FIFO not full.
- request  out  P_REQUESTER_NUM  bit i is set when FIFO i is non-empty; connects to the arbiter `request` input.
- grant_valid  in  P_REQUESTER_NUM  one-hot grant from the arbiter.
- grant_ready  out  1  grant release to the arbiter.
- out_data  out  P_DATA_W  forwarded payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accept.
- grant_err  out  1  sticky protocol-error flag.

## Operation
- FIFO i push when in_valid[i] & in_ready[i]; in_ready[i] = ~full_i.
- No write-through bypass: a push into an empty FIFO makes request[i] rise on the next cycle.
- A full FIFO that is popped in a cycle still refuses a push in that same cycle.
- Pointers are log2(P_FIFO_DEPTH) bits wide and wrap modulo depth. The count is log2(P_FIFO_DEPTH)+1 bits wide.
- FSM states:
  - IDLE: out_valid=0, grant_ready=0.
    - A grant is valid when grant_valid is one-hot and the granted FIFO is non-empty.
    - On a valid grant: latch the grant index, load the head word into out_data, pop the FIFO, move to SEND.
    - If grant_valid is non-zero but not one-hot, or targets an empty FIFO: set grant_err, stay in IDLE, pop nothing.
    - grant_valid=0: stay in IDLE.
  - SEND: out_valid=1 and out_data is held stable. On out_valid & out_ready, move to ACK.
  - ACK: grant_ready=1 for exactly one cycle, then return to IDLE.
    - The arbiter drops its grant at the same edge, so grant_valid is 0 in the following IDLE cycle.
- grant_ready is never asserted while grant_valid=0.
- grant_valid changing while in SEND or ACK sets grant_err. The transfer still completes with the latched index.
- grant_err clears only on reset.
- Reset, including reset mid-transfer:
  - FSM goes to IDLE and all FIFOs are flushed.
  - request=0, in_ready=all 1s, out_valid=0, out_data=0, grant_ready=0, grant_err=0.
  - An in-flight word is discarded.

## Timing
- Grant seen in IDLE at cycle t → out_valid=1 at t+1. The FIFO pop is at edge t→t+1, and request[i] reflects the post-pop count at t+1.
- Downstream handshake at cycle s → grant_ready=1 at s+1 → back in IDLE at s+2.
- Minimum spacing from one grant to the next captured grant is 4 cycles: IDLE, SEND, ACK, plus the arbiter's zero-grant cycle.
- grant_ready is a registered output (default build).
- out_data/out_valid follow AXI-style rules: once asserted, out_valid stays high and out_data stays stable until out_ready.

## Configuration
- Macro ARBITER_GRANT_MUX_EARLY_ACK_EN.
- Defined:
  - grant_ready is combinational: IDLE & valid one-hot grant & non-empty target.
  - It fires in the capture cycle, and the ACK state is removed: SEND returns to IDLE on the downstream handshake.
  - The arbiter is released before the downstream accepts.
  - grant_valid changes during SEND are legal and do not set grant_err.
  - Grant-to-grant spacing tracks downstream acceptance rather than the ACK cycle.
- Undefined: registered grant_ready after the downstream handshake, as described above.

## Test plan
- Reset with in_valid=3'b111 held → request=0, in_ready=3'b111, out_valid=0, grant_err=0. First push of 0xA0 into FIFO 0 → request=3'b001 one cycle later.
- Push 4 words into FIFO 1 (depth 4) → in_ready[1]=0. A fifth push is refused. Grant 3'b010 → out_data=first word at t+1, then in_ready[1]=1.
- FIFOs 0/1/2 preloaded with 0x10/0x20/0x30 and weights 5/3/2 on the paired arbiter → out_data order matches the arbiter grant order. Each transfer shows grant_ready as a 1-cycle pulse 1 cycle after the handshake.
- out_ready held low for 10 cycles in SEND → out_valid and out_data stable and grant_ready=0 throughout. Release → grant_ready pulse at the next cycle.
- grant_valid=3'b011, or a grant to an empty FIFO → no pop, out_valid stays 0, grant_err=1 and sticky until rst_n is low.
- rst_n asserted low asynchronously mid-SEND → out_valid and request drop to 0 immediately. After release, FIFOs are empty.
